// File: rtl/eit_scan_sequencer.sv
// Adjacent-drive EIT scan master: walks injection/measurement pairs and handshakes each step with the slave.
// Optional wait watchdog and ERROR state are compiled in with EIT_SCAN_TIMEOUT_EN.
module eit_scan_sequencer #(
  parameter int N_ELEC         = 16,
  parameter int IDX_W          = 4,
  parameter int TAG_W          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic             fsm_done,
  input  logic             fsm_busy,
  output logic             step_done,
  output logic [IDX_W-1:0] inj_src,
  output logic [IDX_W-1:0] inj_sink,
  output logic [IDX_W-1:0] meas_pos,
  output logic [IDX_W-1:0] meas_neg,
  output logic [TAG_W-1:0] meas_tag,
  output logic             scan_busy,
  output logic             frame_done,
  output logic [15:0]      frame_count,
  output logic             err
);

`ifdef EIT_SCAN_TIMEOUT_EN
  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_ERROR
  } state_t;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
`else
  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT
  } state_t;
`endif

  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_ELEC - 1);
  localparam logic [IDX_W-1:0] LAST_M = IDX_W'(N_ELEC - 4);

  if (N_ELEC < 4 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("eit_scan_sequencer: bad parameters");
  end

  function automatic logic [IDX_W-1:0] add_mod(
    input logic [IDX_W-1:0] x,
    input int unsigned      k
  );
    logic [IDX_W:0] s;
    s = {1'b0, x} + (IDX_W+1)'(k);
    if (s >= (IDX_W+1)'(N_ELEC))
      s = s - (IDX_W+1)'(N_ELEC);
    return s[IDX_W-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] mc_q, mc_d;
  logic [IDX_W-1:0] sink_q, sink_d;
  logic [IDX_W-1:0] neg_q, neg_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [15:0]      fc_q, fc_d;
  logic             stop_q, stop_d;
  logic             step_q, step_d;
  logic             fdone_q, fdone_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             stop_eff;
  logic             last_step;
`ifdef EIT_SCAN_TIMEOUT_EN
  logic [WD_W-1:0]  wd_q, wd_d;
`endif

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    mc_d      = mc_q;
    tag_d     = tag_q;
    fc_d      = fc_q;
    stop_d    = stop_q;
    step_d    = 1'b0;
    fdone_d   = 1'b0;
    err_d     = err_q;
    stop_eff  = stop_q | stop;
    last_step = (i_q == LAST_I) && (mc_q == LAST_M);
    if (busy_q)
      stop_d = stop_eff;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          i_d     = '0;
          j_d     = IDX_W'(2);
          mc_d    = '0;
          tag_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (stop_eff) begin
          state_d = S_IDLE;
        end else if (!fsm_busy) begin
          step_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fsm_done) begin
          if (last_step) begin
            fdone_d = 1'b1;
            fc_d    = fc_q + 16'd1;
            if (cont && !stop_eff) begin
              i_d     = '0;
              j_d     = IDX_W'(2);
              mc_d    = '0;
              tag_d   = '0;
              state_d = S_ISSUE;
            end else begin
              state_d = S_IDLE;
            end
          end else if (stop_eff) begin
            state_d = S_IDLE;
          end else begin
            tag_d   = tag_q + TAG_W'(1);
            state_d = S_ISSUE;
            if (mc_q < LAST_M) begin
              j_d  = add_mod(j_q, 1);
              mc_d = mc_q + IDX_W'(1);
            end else begin
              i_d  = i_q + IDX_W'(1);
              j_d  = add_mod(i_q, 3);
              mc_d = '0;
            end
          end
        end
`ifdef EIT_SCAN_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end
`endif
      end
`ifdef EIT_SCAN_TIMEOUT_EN
      S_ERROR: begin
        if (start && !stop) begin
          err_d   = 1'b0;
          i_d     = '0;
          j_d     = IDX_W'(2);
          mc_d    = '0;
          tag_d   = '0;
          state_d = S_ISSUE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE)
      stop_d = 1'b0;
    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    sink_d = add_mod(i_d, 1);
    neg_d  = add_mod(j_d, 1);
  end

`ifdef EIT_SCAN_TIMEOUT_EN
  // Counts WAIT cycles; any entry into WAIT restarts it at zero.
  assign wd_d = (state_q == S_WAIT && state_d == S_WAIT)
              ? wd_q + WD_W'(1) : '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      mc_q    <= '0;
      sink_q  <= '0;
      neg_q   <= '0;
      tag_q   <= '0;
      fc_q    <= '0;
      stop_q  <= 1'b0;
      step_q  <= 1'b0;
      fdone_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef EIT_SCAN_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      mc_q    <= mc_d;
      sink_q  <= sink_d;
      neg_q   <= neg_d;
      tag_q   <= tag_d;
      fc_q    <= fc_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      fdone_q <= fdone_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef EIT_SCAN_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign step_done   = step_q;
  assign inj_src     = i_q;
  assign inj_sink    = sink_q;
  assign meas_pos    = j_q;
  assign meas_neg    = neg_q;
  assign meas_tag    = tag_q;
  assign scan_busy   = busy_q;
  assign frame_done  = fdone_q;
  assign frame_count = fc_q;
  assign err         = err_q;

endmodule

// File: tb/tb_eit_scan_sequencer.sv
// Randomized bench for eit_scan_sequencer against an arithmetic pair-sequence model.
// Define EIT_SCAN_TIMEOUT_EN for both files to exercise the watchdog.
module tb_eit_scan_sequencer;
  localparam int N  = 16;
  localparam int NP = N * (N - 3);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cont = 1'b0;
  logic        fsm_done = 1'b0;
  logic        fsm_busy = 1'b0;
  logic        step_done;
  logic [3:0]  inj_src, inj_sink, meas_pos, meas_neg;
  logic [7:0]  meas_tag;
  logic        scan_busy, frame_done, err;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int steps = 0;
  int frames = 0;
  int fc_model = 0;
  int exp_idx = 0;
  bit slave_en = 1'b1;
  bit rand_mode = 1'b0;

  eit_scan_sequencer #(
    .N_ELEC(N), .IDX_W(4), .TAG_W(8), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cont(cont), .fsm_done(fsm_done), .fsm_busy(fsm_busy),
    .step_done(step_done), .inj_src(inj_src),
    .inj_sink(inj_sink), .meas_pos(meas_pos),
    .meas_neg(meas_neg), .meas_tag(meas_tag),
    .scan_busy(scan_busy), .frame_done(frame_done),
    .frame_count(frame_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step n of a frame: injection i = n/(N-3), j = i+2+(n mod (N-3)).
  function automatic logic [31:0] exp_pair(input int n);
    int i, j;
    i = n / (N - 3);
    j = (i + 2 + n % (N - 3)) % N;
    return {8'h00, 4'(i), 4'((i + 1) % N),
            4'(j), 4'((j + 1) % N), 8'(n)};
  endfunction

  function automatic logic [31:0] obs_pair();
    return {8'h00, inj_src, inj_sink, meas_pos, meas_neg, meas_tag};
  endfunction

  // Slave model: answer each step_done after a delay.
  initial begin
    int d;
    logic [31:0] p;
    forever begin
      @(negedge clk);
      if (!rst && step_done) begin
        p = exp_pair(exp_idx % NP);
        chk("pair", obs_pair(), p);
        exp_idx++;
        steps++;
        if (slave_en) begin
          d = rand_mode ? $urandom_range(1, 8) : 5;
          if (rand_mode) fsm_busy = 1'b1;
          repeat (d) @(negedge clk);
          chk("step_pulse", {31'd0, step_done}, 0);
          chk("pair_hold", obs_pair(), p);
          fsm_done = 1'b1;
          @(negedge clk);
          fsm_done = 1'b0;
          repeat (rand_mode ? $urandom_range(0, 3) : 0)
            @(negedge clk);
          fsm_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && frame_done) begin
        frames++;
        fc_model++;
        chk("frame_count", {16'd0, frame_count}, fc_model);
        if (cont) chk("cont_reissue", {31'd0, scan_busy}, 1);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_busy && n < budget);
    chk(tag, {31'd0, scan_busy}, 0);
    @(negedge clk);
  endtask

  initial begin
    int s0, f0, n;
    repeat (3) @(negedge clk);
    chk("rst_idx", obs_pair(), 0);
    chk("rst_ctl", {28'd0, step_done, frame_done, scan_busy, err}, 0);
    chk("rst_fc", {16'd0, frame_count}, 0);
    rst = 1'b0;

    // Full frame, fixed 5-cycle slave reply.
    exp_idx = 0;
    s0 = steps;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", {31'd0, scan_busy}, 1);
    chk("start_early", {31'd0, step_done}, 0);
    @(negedge clk);
    chk("start_latency", {31'd0, step_done}, 1);
    wait_idle(4000, "frame_idle");
    chk("frame_steps", steps - s0, NP);
    chk("frames1", frames, 1);
    chk("fc1", {16'd0, frame_count}, 1);
    chk("last_tag", {24'd0, meas_tag}, NP - 1);
    chk("last_inj", {24'd0, inj_src, inj_sink}, 32'hF0);
    chk("last_meas", {24'd0, meas_pos, meas_neg}, 32'hDE);

    // Busy hold, then a frame with random slave timing.
    rand_mode = 1'b1;
    exp_idx = 0;
    s0 = steps;
    fsm_busy = 1'b1;
    pulse_start();
    repeat (20) @(negedge clk);
    chk("busy_hold", steps - s0, 0);
    fsm_busy = 1'b0;
    @(negedge clk);
    chk("busy_release", {31'd0, step_done}, 1);
    wait_idle(8000, "busy_idle");
    chk("busy_steps", steps - s0, NP);
    chk("fc2", {16'd0, frame_count}, 2);

    // Continuous: two frames with cont, third ends it.
    cont = 1'b1;
    exp_idx = 0;
    s0 = steps;
    f0 = frames;
    pulse_start();
    n = 0;
    while (frames - f0 < 2 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("cont_two", frames - f0, 2);
    cont = 1'b0;
    wait_idle(6000, "cont_idle");
    chk("cont_frames", frames - f0, 3);
    chk("cont_steps", steps - s0, 3 * NP);
    chk("fc5", {16'd0, frame_count}, 5);

    // Stop during step 50 (tag 49).
    rand_mode = 1'b0;
    exp_idx = 0;
    s0 = steps;
    f0 = frames;
    pulse_start();
    n = 0;
    while (steps - s0 < 50 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(200, "stop_idle");
    repeat (20) @(negedge clk);
    chk("stop_steps", steps - s0, 50);
    chk("stop_frames", frames - f0, 0);
    chk("stop_fc", {16'd0, frame_count}, 5);

    // start and stop together in IDLE.
    s0 = steps;
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    repeat (5) @(negedge clk);
    chk("startstop_busy", {31'd0, scan_busy}, 0);
    chk("startstop_steps", steps - s0, 0);

    // Slave never answers.
    slave_en = 1'b0;
    exp_idx = 0;
    s0 = steps;
    pulse_start();
    n = 0;
    while (steps - s0 < 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("nodone_step", steps - s0, 1);
`ifdef EIT_SCAN_TIMEOUT_EN
    repeat (110) @(negedge clk);
    chk("to_err", {31'd0, err}, 1);
    chk("to_busy", {31'd0, scan_busy}, 0);
    exp_idx = 0;
    pulse_start();
    chk("to_clear", {31'd0, err}, 0);
    chk("to_restart", {31'd0, scan_busy}, 1);
`else
    repeat (10000) @(negedge clk);
    chk("nodone_busy", {31'd0, scan_busy}, 1);
    chk("nodone_err", {31'd0, err}, 0);
`endif
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-WAIT.
    #2 rst = 1'b1;
    #1;
    chk("arst_idx", obs_pair(), 0);
    chk("arst_ctl", {28'd0, step_done, frame_done, scan_busy, err}, 0);
    chk("arst_fc", {16'd0, frame_count}, 0);
    fc_model = 0;
    @(negedge clk);
    rst = 1'b0;
    s0 = steps;
    fsm_done = 1'b1;
    @(negedge clk);
    fsm_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", {31'd0, scan_busy}, 0);
    chk("post_rst_steps", steps - s0, 0);
    chk("post_rst_fc", {16'd0, frame_count}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/eit_scan_sequencer.md
# eit_scan_sequencer

Upstream master for the per-step slave FSM. It walks the adjacent-drive EIT pattern: injection pair (i, i+1) and measurement pair (j, j+1), with every measurement pair that touches an injection electrode excluded. For each pair it issues one `step_done` pulse and waits for the slave's `fsm_done`. It counts completed frames and supports single-shot or continuous scanning.

## Interface
- `N_ELEC`, default 16: electrode count, ≥4.
- `IDX_W`, default 4: electrode index width, ≥ clog2(N_ELEC).
- `TAG_W`, default 8: measurement tag width, ≥ clog2(N_ELEC*(N_ELEC-3)).
- `TIMEOUT_CYCLES`, default 4096: watchdog limit; used only with the macro.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a scan; sampled in IDLE/ERROR only.
- `stop`  in  1  request a stop after the current step.
- `cont`  in  1  continuous mode; sampled at frame end.
- `fsm_done`  in  1  slave step complete (1-cycle pulse).
- `fsm_busy`  in  1  slave busy.
- `step_done`  out  1  trigger to slave, 1-cycle pulse.
- `inj_src`, `inj_sink`  out  IDX_W  injection electrodes i, (i+1) mod N.
- `meas_pos`, `meas_neg`  out  IDX_W  measurement electrodes j, (j+1) mod N.
- `meas_tag`  out  TAG_W  linear measurement index within the frame.
- `scan_busy`  out  1  high in every state except IDLE/ERROR.
- `frame_done`  out  1  1-cycle pulse when a frame completes.
- `frame_count`  out  16  completed frames; wraps modulo 2^16.
- `err`  out  1  sticky watchdog error.

## Operation
- States: IDLE, ISSUE, WAIT, ERROR.
- **IDLE**
  - On `start`=1 and `stop`=0: i=0, j=2, tag=0, go to ISSUE.
  - If `start` and `stop` are both high, stop wins and the FSM stays in IDLE.
- **ISSUE**
  - If `fsm_busy`=0: pulse `step_done` and go to WAIT.
  - Otherwise hold in ISSUE.
- **WAIT**
  - `fsm_done`=1 completes the step. The FSM then advances as follows:
    - If `meas_cnt` < N-4: j=(j+1) mod N, tag+1.
    - Otherwise it moves to the next injection: i=i+1, j=(i+3) mod N, meas_cnt=0, tag+1.
    - If the step just completed was the last one (i=N-1 and `meas_cnt`=N-4), the frame is complete:
      - Pulse `frame_done` and increment `frame_count`.
      - If `cont`=1 and no stop is pending, re-initialise (i=0, j=2, tag=0) and go to ISSUE.
      - Otherwise go to IDLE.
  - A latched stop (see `stop` below) sends the FSM to IDLE after the step completes, without `frame_done` unless that step finished the frame.
- **Pair sequence per injection**
  - j runs (i+2)…(i+N-2) mod N, giving N-3 pairs per injection and N*(N-3) pairs per frame (208 for N=16).
  - j never equals i-1, i or i+1 (mod N).
- **`stop`**
  - Latched while `scan_busy` is high and cleared on entering IDLE.
  - In ISSUE, a pending stop goes straight to IDLE with no `step_done`.
- `fsm_done` is ignored outside WAIT.
- **Index stability**
  - All index outputs and `meas_tag` are stable from the `step_done` cycle until the cycle after `fsm_done`.
  - In IDLE they hold their last values.
- `rst` mid-operation forces reset values immediately, with no completion handshake.

## Timing
- **Reset values:**
  - `step_done`, `frame_done`, `scan_busy` and `err` are 0.
  - All indices and `meas_tag` are 0.
  - `frame_count` is 0, and the state is IDLE.
- **Start latency:** with `fsm_busy` low, `step_done` is high 2 cycles after the edge that samples `start` (the IDLE→ISSUE edge, then the registered pulse).
- **Step-to-step gap:** the sampled `fsm_done` edge leads to ISSUE. The next `step_done` occurs on the first subsequent edge with `fsm_busy` sampled low.
- `frame_done` and the `frame_count` increment happen on the same edge as the transition out of WAIT.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- Macro: `EIT_SCAN_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in WAIT and clears on entry.
  - If it reaches `TIMEOUT_CYCLES` without `fsm_done`, the FSM goes to ERROR: `err`=1, `scan_busy`=0.
  - ERROR exits only on `start`, which clears `err` and restarts from i=0. `rst` also clears it.
- **Undefined:** there is no counter and no ERROR state; WAIT waits indefinitely and `err` is tied to 0 (the port is kept).

## Test plan
- **Full frame:** N=16, `cont`=0, one `start`, slave model replying after 5 cycles.
  - Exactly 208 `step_done` pulses.
  - First pair: inj 0/1, meas 2/3, tag 0. Last pair: inj 15/0, meas 13/14, tag 207.
  - One `frame_done` pulse, `frame_count`=1, then IDLE.
- **Busy hold:** `fsm_busy` held high for 20 cycles after `start` → no `step_done` during that time; the pulse appears 1 edge after `fsm_busy` is sampled low.
- **Continuous:** `cont`=1 for 2 frames → 416 steps, `frame_count`=2, and ISSUE directly follows the frame end. Then drop `cont` → IDLE after frame 3.
- **Stop:** assert `stop` during step 50 (tag 49) → that step completes, no further `step_done`, IDLE, no `frame_done`, `frame_count` unchanged. `start`+`stop` together in IDLE → no action.
- **Timeout:** with the macro and `TIMEOUT_CYCLES`=100, `fsm_done` is never returned → `err`=1 and `scan_busy`=0 about 100 cycles after `step_done`; `start` clears `err`. Without the macro → still in WAIT with `err`=0 after 10000 cycles.
- **Reset mid-WAIT:** assert `rst` mid-WAIT → all outputs at reset values in the same cycle; `fsm_done` after reset is ignored.
